ibuff_inst_extract: RTL and testbench

- Read side of the fetch-stage instruction buffer. The fetch stage writes 128-bit cache lines into four IBuff slots: slots 0/2 hold even lines, slots 1/3 hold odd lines.
- This block reads those slots in program order and extracts one 32-bit instruction per cycle with its PC.
- It presents each instruction to decode over a valid/ready handshake.
- It frees each slot through the IBuff invalidate vector once all four words of that slot have been consumed.
- Sits between IBuff and the D1 decode stage; flushed on every resteer.

---
 rtl/ibuff_inst_extract.sv | 127 ++++++++++++
 tb/tb_ibuff_inst_extract.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ibuff_inst_extract.sv
// ibuff_inst_extract
//   Read side of the fetch-stage instruction buffer. Walks the four IBuff
//   slots in program order, extracts one 32-bit instruction per cycle with
//   its PC, hands it to decode over a valid/ready handshake, and frees each
//   slot once all four of its words have been consumed.
//
// Ports
//   clk, rst         clock and synchronous active-high reset
//   flush, flush_pc  resteer: drop everything and restart at flush_pc
//   slot_data_flat   IBuff slot contents, slot k at [k*CL_SIZE +: CL_SIZE]
//   slot_valid       IBuff slot valid bits
//   slot_invalidate  registered one-cycle pulses that free IBuff slots
//   inst_out,inst_pc instruction and its PC presented to decode
//   inst_valid       inst_out/inst_pc are valid
//   dec_ready        decode accepts this cycle
//   starve_cnt       saturating count of cycles spent waiting for a slot
module ibuff_inst_extract #(
  parameter int XLEN    = 32,
  parameter int CL_SIZE = 128,
  parameter int NSLOT   = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic [XLEN-1:0]          flush_pc,
  input  logic [NSLOT*CL_SIZE-1:0] slot_data_flat,
  input  logic [NSLOT-1:0]         slot_valid,
  output logic [NSLOT-1:0]         slot_invalidate,
  output logic [31:0]              inst_out,
  output logic [XLEN-1:0]          inst_pc,
  output logic                     inst_valid,
  input  logic                     dec_ready,
  output logic [15:0]              starve_cnt
);

  typedef enum logic {WAIT, STREAM} state_t;

  state_t           state, state_nxt;
  logic [1:0]       rd_slot, rd_slot_nxt;
  logic [1:0]       off, off_nxt;
  logic [XLEN-1:0]  pc, pc_nxt;
  logic [NSLOT-1:0] inv_nxt;
  logic             valid_nxt;
  logic             can_extract;
  logic             take;
  logic             load;
  logic [31:0]      word_sel;

  // A slot that is being invalidated this cycle may still look valid on the
  // IBuff side; masking it keeps a freed slot (including every slot after a
  // flush) from being read before IBuff has really re-validated it.
  assign can_extract = slot_valid[rd_slot] & ~slot_invalidate[rd_slot];
  assign take        = ~inst_valid | dec_ready;
  assign load        = can_extract & take & ~flush;

  // Word mux: constant part-selects only, one per (slot, word) pair.
  always_comb begin
    word_sel = '0;
    for (int k = 0; k < NSLOT; k++) begin
      for (int w = 0; w < 4; w++) begin
        if (rd_slot == 2'(k) && off == 2'(w))
          word_sel = slot_data_flat[k*CL_SIZE + 32*w +: 32];
      end
    end
  end

  // Next-state logic: flush restarts the pointers; otherwise a load advances
  // pc/off and, on the last word of a slot, retires it and moves to the next.
  always_comb begin
    state_nxt   = state;
    rd_slot_nxt = rd_slot;
    off_nxt     = off;
    pc_nxt      = pc;
    inv_nxt     = '0;
    valid_nxt   = inst_valid;
    if (flush) begin
      valid_nxt   = 1'b0;
      inv_nxt     = '1;
      pc_nxt      = flush_pc;
      off_nxt     = flush_pc[3:2];
      rd_slot_nxt = {1'b0, flush_pc[4]};
      state_nxt   = WAIT;
    end else begin
      if (take)
        valid_nxt = can_extract;
      if (load) begin
        pc_nxt  = pc + XLEN'(4);
        off_nxt = off + 2'd1;
        if (off == 2'd3) begin
          inv_nxt[rd_slot] = 1'b1;
          rd_slot_nxt      = rd_slot + 2'd1;
        end
      end
      state_nxt = slot_valid[rd_slot_nxt] ? STREAM : WAIT;
    end
  end

  // State, pointers and output register. inst_out/inst_pc only change on a
  // load, which gives the hold behaviour under backpressure for free.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= WAIT;
      rd_slot         <= 2'd0;
      off             <= 2'd0;
      pc              <= '0;
      inst_out        <= '0;
      inst_pc         <= '0;
      inst_valid      <= 1'b0;
      slot_invalidate <= '0;
      starve_cnt      <= '0;
    end else begin
      state           <= state_nxt;
      rd_slot         <= rd_slot_nxt;
      off             <= off_nxt;
      pc              <= pc_nxt;
      inst_valid      <= valid_nxt;
      slot_invalidate <= inv_nxt;
      if (load) begin
        inst_out <= word_sel;
        inst_pc  <= pc;
      end
      if (state == WAIT && !flush && starve_cnt != 16'hFFFF)
        starve_cnt <= starve_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_ibuff_inst_extract.sv
// tb_ibuff_inst_extract
//   Self-checking bench for ibuff_inst_extract. Expected instructions are
//   pushed into a scoreboard queue when slot data is driven; a negedge
//   monitor compares every presented instruction with the queue head and
//   pops it on a handshake. A cycle table covers streaming, slot retire and
//   backpressure; hand-written sequences cover wrap, flush and reset.
module tb_ibuff_inst_extract;

  localparam int XLEN    = 32;
  localparam int CL_SIZE = 128;

  logic             clk;
  logic             rst;
  logic             flush;
  logic [XLEN-1:0]  flush_pc;
  logic [4*CL_SIZE-1:0] slot_data_flat;
  logic [3:0]       slot_valid;
  logic [3:0]       slot_invalidate;
  logic [31:0]      inst_out;
  logic [XLEN-1:0]  inst_pc;
  logic             inst_valid;
  logic             dec_ready;
  logic [15:0]      starve_cnt;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
  } exp_t;

  exp_t sb[$];

  typedef struct {
    logic [3:0]  sv;
    logic        rdy;
    logic        ev;
    logic [31:0] ei;
    logic [31:0] ep;
    logic [3:0]  einv;
  } vec_t;

  vec_t tbl[14];

  ibuff_inst_extract #(.XLEN(XLEN), .CL_SIZE(CL_SIZE), .NSLOT(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .flush          (flush),
    .flush_pc       (flush_pc),
    .slot_data_flat (slot_data_flat),
    .slot_valid     (slot_valid),
    .slot_invalidate(slot_invalidate),
    .inst_out       (inst_out),
    .inst_pc        (inst_pc),
    .inst_valid     (inst_valid),
    .dec_ready      (dec_ready),
    .starve_cnt     (starve_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Inputs change 1ns after the rising edge; outputs are read there too.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic [3:0] sv, input logic rdy, input logic fl,
                                input logic [31:0] fpc);
    slot_valid = sv;
    dec_ready  = rdy;
    flush      = fl;
    flush_pc   = fpc;
  endtask

  task automatic set_slot(input int k, input logic [31:0] base);
    for (int w = 0; w < 4; w++)
      slot_data_flat[k*CL_SIZE + 32*w +: 32] = base + 32'(w);
  endtask

  task automatic push_words(input logic [31:0] base, input int first, input logic [31:0] pc0);
    for (int w = first; w < 4; w++) begin
      exp_t e;
      e.inst = base + 32'(w);
      e.pc   = pc0 + 32'(4 * (w - first));
      sb.push_back(e);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    apply_stimulus(4'b0000, 1'b0, 1'b0, '0);
    step();
    step();
    sb.delete();
    rst = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 30) begin
      step();
      n++;
    end
    check_output(name, 32'(sb.size()), 32'd0);
  endtask

  // Scoreboard monitor: whatever is presented must be the queue head.
  always @(negedge clk) begin
    if (!rst && inst_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL sb_unexpected: got inst %h pc %h expected nothing", inst_out, inst_pc);
      end else begin
        check_output("sb_inst", inst_out, sb[0].inst);
        check_output("sb_pc", inst_pc, sb[0].pc);
        if (dec_ready)
          void'(sb.pop_front());
      end
    end
  end

  initial begin
    slot_data_flat = '0;
    tbl[0]  = '{4'b0001, 1'b1, 1'b1, 32'hD000_0000, 32'h00, 4'b0000};
    tbl[1]  = '{4'b0001, 1'b1, 1'b1, 32'hD000_0001, 32'h04, 4'b0000};
    tbl[2]  = '{4'b0001, 1'b1, 1'b1, 32'hD000_0002, 32'h08, 4'b0000};
    tbl[3]  = '{4'b0001, 1'b1, 1'b1, 32'hD000_0003, 32'h0C, 4'b0001};
    tbl[4]  = '{4'b0001, 1'b1, 1'b0, 32'h0,         32'h00, 4'b0000};
    tbl[5]  = '{4'b0001, 1'b1, 1'b0, 32'h0,         32'h00, 4'b0000};
    tbl[6]  = '{4'b0011, 1'b1, 1'b1, 32'hE000_0000, 32'h10, 4'b0000};
    tbl[7]  = '{4'b0011, 1'b0, 1'b1, 32'hE000_0000, 32'h10, 4'b0000};
    tbl[8]  = '{4'b0011, 1'b0, 1'b1, 32'hE000_0000, 32'h10, 4'b0000};
    tbl[9]  = '{4'b0011, 1'b0, 1'b1, 32'hE000_0000, 32'h10, 4'b0000};
    tbl[10] = '{4'b0011, 1'b1, 1'b1, 32'hE000_0001, 32'h14, 4'b0000};
    tbl[11] = '{4'b0011, 1'b1, 1'b1, 32'hE000_0002, 32'h18, 4'b0000};
    tbl[12] = '{4'b0011, 1'b1, 1'b1, 32'hE000_0003, 32'h1C, 4'b0010};
    tbl[13] = '{4'b0011, 1'b1, 1'b0, 32'h0,         32'h00, 4'b0000};

    // Reset values and starvation counting.
    do_reset();
    check_output("rst_valid", 32'(inst_valid), 32'd0);
    check_output("rst_inst", inst_out, 32'd0);
    check_output("rst_pc", inst_pc, 32'd0);
    check_output("rst_inv", 32'(slot_invalidate), 32'd0);
    check_output("rst_starve", 32'(starve_cnt), 32'd0);
    for (int i = 0; i < 10; i++) begin
      step();
      check_output("starve_valid", 32'(inst_valid), 32'd0);
    end
    check_output("starve_cnt", 32'(starve_cnt), 32'd10);

    // Cycle table: slot 0 stream, retire, wait, then slot 1 with backpressure.
    set_slot(0, 32'hD000_0000);
    set_slot(1, 32'hE000_0000);
    push_words(32'hD000_0000, 0, 32'h00);
    push_words(32'hE000_0000, 0, 32'h10);
    for (int i = 0; i < 14; i++) begin
      apply_stimulus(tbl[i].sv, tbl[i].rdy, 1'b0, '0);
      step();
      check_output($sformatf("tbl%0d_valid", i), 32'(inst_valid), 32'(tbl[i].ev));
      if (tbl[i].ev) begin
        check_output($sformatf("tbl%0d_inst", i), inst_out, tbl[i].ei);
        check_output($sformatf("tbl%0d_pc", i), inst_pc, tbl[i].ep);
      end
      check_output($sformatf("tbl%0d_inv", i), 32'(slot_invalidate), 32'(tbl[i].einv));
    end
    check_output("tbl_sb_empty", 32'(sb.size()), 32'd0);

    // Wrap through all four slots; the bench plays IBuff and drops a slot
    // as soon as its invalidate pulse is expected.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      set_slot(k, 32'hA000_0000 + 32'(k << 8));
      push_words(32'hA000_0000 + 32'(k << 8), 0, 32'(16 * k));
    end
    apply_stimulus(4'b1111, 1'b1, 1'b0, '0);
    for (int i = 1; i <= 16; i++) begin
      logic [3:0] exp_inv;
      exp_inv = (i % 4 == 0) ? (4'b0001 << (i / 4 - 1)) : 4'b0000;
      step();
      check_output($sformatf("wrap%0d_pc", i), inst_pc, 32'(4 * (i - 1)));
      check_output($sformatf("wrap%0d_inv", i), 32'(slot_invalidate), 32'(exp_inv));
      slot_valid = slot_valid & ~exp_inv;
    end
    step();
    check_output("wrap_idle_valid", 32'(inst_valid), 32'd0);
    set_slot(0, 32'hF000_0000);
    push_words(32'hF000_0000, 0, 32'h40);
    slot_valid = 4'b0001;
    step();
    check_output("wrap_back_valid", 32'(inst_valid), 32'd1);
    check_output("wrap_back_pc", inst_pc, 32'h40);
    step();

    // Flush while streaming; the stale slot stays valid through the
    // invalidate cycle and must not be read.
    apply_stimulus(4'b0001, 1'b1, 1'b1, 32'h0000_1008);
    step();
    check_output("flush_valid", 32'(inst_valid), 32'd0);
    check_output("flush_inv", 32'(slot_invalidate), 32'hF);
    sb.delete();
    flush = 1'b0;
    step();
    check_output("flush_inv_cycle_valid", 32'(inst_valid), 32'd0);
    check_output("flush_inv_done", 32'(slot_invalidate), 32'd0);
    slot_valid = 4'b0000;
    step();
    check_output("flush_idle_valid", 32'(inst_valid), 32'd0);
    set_slot(0, 32'h4400_0000);
    set_slot(1, 32'h4500_0000);
    push_words(32'h4400_0000, 2, 32'h1008);
    push_words(32'h4500_0000, 0, 32'h1010);
    slot_valid = 4'b0011;
    step();
    check_output("flush_first_valid", 32'(inst_valid), 32'd1);
    check_output("flush_first_inst", inst_out, 32'h4400_0002);
    check_output("flush_first_pc", inst_pc, 32'h1008);
    drain("flush_sb_drain");

    // Flush coinciding with an accepted instruction, then reset mid-stream.
    do_reset();
    set_slot(0, 32'h6600_0000);
    push_words(32'h6600_0000, 0, 32'h0);
    apply_stimulus(4'b0001, 1'b1, 1'b0, '0);
    step();
    step();
    check_output("acc_pre_pc", inst_pc, 32'h4);
    apply_stimulus(4'b0001, 1'b1, 1'b1, 32'h0000_2014);
    step();
    check_output("acc_flush_valid", 32'(inst_valid), 32'd0);
    check_output("acc_flush_inv", 32'(slot_invalidate), 32'hF);
    check_output("acc_flush_popped", 32'(sb.size()), 32'd2);
    sb.delete();
    apply_stimulus(4'b0000, 1'b1, 1'b0, '0);
    step();
    set_slot(1, 32'h7700_0000);
    push_words(32'h7700_0000, 1, 32'h2014);
    slot_valid = 4'b0010;
    step();
    check_output("acc_resume_pc", inst_pc, 32'h2014);
    check_output("acc_resume_inst", inst_out, 32'h7700_0001);
    step();
    rst = 1'b1;
    apply_stimulus(4'b0010, 1'b0, 1'b1, 32'h0000_3000);
    step();
    check_output("mrst_valid", 32'(inst_valid), 32'd0);
    check_output("mrst_inst", inst_out, 32'd0);
    check_output("mrst_pc", inst_pc, 32'd0);
    check_output("mrst_inv", 32'(slot_invalidate), 32'd0);
    check_output("mrst_starve", 32'(starve_cnt), 32'd0);
    sb.delete();
    rst = 1'b0;
    apply_stimulus(4'b0000, 1'b1, 1'b0, '0);
    step();
    check_output("post_rst_valid", 32'(inst_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard stop in case the stimulus sequence itself ever stalls.
  initial begin
    #100000;
    $display("[TB] FAIL timeout: got no end of test expected finish");
    $fatal(1, "[TB] timeout");
  end

endmodule
